// File: rtl/dco_code_mapper.sv
// dco_code_mapper
// Maps the signed DCO control code from the loop filter onto the unsigned
// ring-oscillator frequency-select word (f_sel = BIAS +/- code).
// The word saturates at the RO range and is slew-limited so that large code
// jumps reach the oscillator as a bounded ramp instead of a single glitch.
// Freeze, settle and saturation status are reported alongside.
module dco_code_mapper #(
   parameter int RO_WIDTH     = 8,
   parameter int DCO_CC_WIDTH = 9,
   parameter int BIAS         = 127,
   parameter int INVERT       = 0,
   parameter int MAX_STEP     = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [DCO_CC_WIDTH-1:0] dco_cc_i,
   input  logic                    cc_valid_i,
   input  logic                    freeze_i,
   output logic [RO_WIDTH-1:0]     f_sel_o,
   output logic [RO_WIDTH-1:0]     target_o,
   output logic                    sat_hi_o,
   output logic                    sat_lo_o,
   output logic                    settled_o
);

   // Common signed width for the BIAS/code sum: wide enough that neither the
   // sign-extended code nor the zero-extended bias can overflow the addition.
   localparam int SW = ((RO_WIDTH > DCO_CC_WIDTH) ? RO_WIDTH : DCO_CC_WIDTH) + 2;
   // Width for the target/f_sel difference (two unsigned RO words, signed result).
   localparam int DW = RO_WIDTH + 2;

   localparam logic [RO_WIDTH-1:0] BIAS_RO = RO_WIDTH'(BIAS);
   localparam logic [RO_WIDTH-1:0] RO_MAX  = {RO_WIDTH{1'b1}};
   localparam logic [RO_WIDTH-1:0] STEP_RO = RO_WIDTH'(MAX_STEP);
   localparam bit                  INV     = (INVERT != 0);
   localparam bit                  NO_LIMIT = (MAX_STEP == 0);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_SLEW,
      ST_SETTLED,
      ST_FROZEN
   } state_t;

   state_t state_reg, state_next;

   logic [RO_WIDTH-1:0] f_sel_reg, f_sel_next;
   logic [RO_WIDTH-1:0] target_reg, target_next;
   logic                sat_hi_reg, sat_hi_next;
   logic                sat_lo_reg, sat_lo_next;
   logic                settled_reg, settled_next;

   // Target-stage intermediates
   logic                 accept;
   logic signed [SW-1:0] code_ext;
   logic signed [SW-1:0] bias_ext;
   logic signed [SW-1:0] ro_max_ext;
   logic signed [SW-1:0] sum;
   logic [RO_WIDTH-1:0]  target_cand;
   logic                 sat_hi_cand;
   logic                 sat_lo_cand;

   // Slew-stage intermediates
   logic signed [DW-1:0] diff;
   logic signed [DW-1:0] abs_diff;
   logic [RO_WIDTH-1:0]  slew_val;

   // A code is taken only while freeze is low; a code arriving with freeze
   // (including in INIT or on the same edge freeze rises) is dropped.
   assign accept = cc_valid_i & ~freeze_i;

   // Form BIAS +/- code at full precision and clamp it into the RO range.
   always_comb begin
      code_ext    = {{(SW-DCO_CC_WIDTH){dco_cc_i[DCO_CC_WIDTH-1]}}, dco_cc_i};
      bias_ext    = {{(SW-RO_WIDTH){1'b0}}, BIAS_RO};
      ro_max_ext  = {{(SW-RO_WIDTH){1'b0}}, RO_MAX};
      sum         = INV ? (bias_ext - code_ext) : (bias_ext + code_ext);
      target_cand = sum[RO_WIDTH-1:0];
      sat_hi_cand = 1'b0;
      sat_lo_cand = 1'b0;
      if (sum < 0) begin
         target_cand = '0;
         sat_lo_cand = 1'b1;
      end else if (sum > ro_max_ext) begin
         target_cand = RO_MAX;
         sat_hi_cand = 1'b1;
      end
   end

   // One slew step from the current word toward the registered target;
   // stepping only while |diff| > MAX_STEP guarantees no overshoot or wrap.
   always_comb begin
      diff     = signed'({2'b00, target_reg}) - signed'({2'b00, f_sel_reg});
      abs_diff = (diff < 0) ? -diff : diff;
      slew_val = target_reg;
      if (!NO_LIMIT && (int'(abs_diff) > MAX_STEP)) begin
         if (diff > 0) begin
            slew_val = f_sel_reg + STEP_RO;
         end else begin
            slew_val = f_sel_reg - STEP_RO;
         end
      end
   end

   // Next-state and next-register values for the mapper FSM.
   always_comb begin
      state_next  = state_reg;
      f_sel_next  = f_sel_reg;
      target_next = target_reg;
      sat_hi_next = sat_hi_reg;
      sat_lo_next = sat_lo_reg;

      if (accept) begin
         target_next = target_cand;
         sat_hi_next = sat_hi_cand;
         sat_lo_next = sat_lo_cand;
      end

      case (state_reg)
         ST_INIT: begin
            if (accept) begin
               state_next = ST_SLEW;
            end
         end
         ST_SLEW: begin
            if (freeze_i) begin
               state_next = ST_FROZEN;
            end else begin
               // Slew uses the target registered last edge; a retarget on this
               // edge is picked up by the next step without any restart gap.
               f_sel_next = slew_val;
               state_next = (slew_val == target_next) ? ST_SETTLED : ST_SLEW;
            end
         end
         ST_SETTLED: begin
            if (freeze_i) begin
               state_next = ST_FROZEN;
            end else if (accept && (target_cand != f_sel_reg)) begin
               state_next = ST_SLEW;
            end
         end
         ST_FROZEN: begin
            if (!freeze_i) begin
               state_next = (f_sel_reg == target_next) ? ST_SETTLED : ST_SLEW;
            end
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase

      settled_next = (state_next == ST_SETTLED);
   end

   // State and datapath registers; reset forces the centre word at once,
   // even in the middle of a ramp.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg   <= ST_INIT;
         f_sel_reg   <= BIAS_RO;
         target_reg  <= BIAS_RO;
         sat_hi_reg  <= 1'b0;
         sat_lo_reg  <= 1'b0;
         settled_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         f_sel_reg   <= f_sel_next;
         target_reg  <= target_next;
         sat_hi_reg  <= sat_hi_next;
         sat_lo_reg  <= sat_lo_next;
         settled_reg <= settled_next;
      end
   end

   assign f_sel_o   = f_sel_reg;
   assign target_o  = target_reg;
   assign sat_hi_o  = sat_hi_reg;
   assign sat_lo_o  = sat_lo_reg;
   assign settled_o = settled_reg;

endmodule

// File: tb/tb_dco_code_mapper.sv
// tb_dco_code_mapper
// Directed bench for dco_code_mapper. Three instances share the stimulus:
// default parameters, INVERT=1, and MAX_STEP=0. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point after the next edge.
module tb_dco_code_mapper;

   logic       clk_i;
   logic       rst_n_i;
   logic [8:0] dco_cc_i;
   logic       cc_valid_i;
   logic       freeze_i;

   logic [7:0] f_sel_o,    target_o;
   logic       sat_hi_o,   sat_lo_o,   settled_o;
   logic [7:0] f_sel_inv,  target_inv;
   logic       sat_hi_inv, sat_lo_inv, settled_inv;
   logic [7:0] f_sel_ns,   target_ns;
   logic       sat_hi_ns,  sat_lo_ns,  settled_ns;

   int total = 0;
   int bad   = 0;

   dco_code_mapper dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .dco_cc_i(dco_cc_i),
      .cc_valid_i(cc_valid_i), .freeze_i(freeze_i),
      .f_sel_o(f_sel_o), .target_o(target_o), .sat_hi_o(sat_hi_o),
      .sat_lo_o(sat_lo_o), .settled_o(settled_o)
   );

   dco_code_mapper #(.INVERT(1)) dut_inv (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .dco_cc_i(dco_cc_i),
      .cc_valid_i(cc_valid_i), .freeze_i(freeze_i),
      .f_sel_o(f_sel_inv), .target_o(target_inv), .sat_hi_o(sat_hi_inv),
      .sat_lo_o(sat_lo_inv), .settled_o(settled_inv)
   );

   dco_code_mapper #(.MAX_STEP(0)) dut_ns (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .dco_cc_i(dco_cc_i),
      .cc_valid_i(cc_valid_i), .freeze_i(freeze_i),
      .f_sel_o(f_sel_ns), .target_o(target_ns), .sat_hi_o(sat_hi_ns),
      .sat_lo_o(sat_lo_ns), .settled_o(settled_ns)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_n_i    = 1'b0;
      cc_valid_i = 1'b0;
      freeze_i   = 1'b0;
      dco_cc_i   = '0;
      tick();
      tick();
      rst_n_i = 1'b1;
   endtask

   // Present one code for one edge, then drop the strobe.
   task automatic send_code(input int code, input logic frz);
      logic [31:0] c32;
      c32        = code;
      dco_cc_i   = c32[8:0];
      cc_valid_i = 1'b1;
      freeze_i   = frz;
      tick();
      cc_valid_i = 1'b0;
      $display("code %0d freeze=%0b -> f_sel=%0d target=%0d hi=%0b lo=%0b settled=%0b",
               code, frz, f_sel_o, target_o, sat_hi_o, sat_lo_o, settled_o);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (f_sel_o !== 8'd127) begin bad++; $display("FAIL reset_f_sel got=%0d exp=127", f_sel_o); end
      total++; if (target_o !== 8'd127) begin bad++; $display("FAIL reset_target got=%0d exp=127", target_o); end
      total++; if (settled_o !== 1'b0) begin bad++; $display("FAIL reset_settled got=%0b exp=0", settled_o); end
      total++; if ({sat_hi_o, sat_lo_o} !== 2'b00) begin bad++; $display("FAIL reset_sat got=%b exp=00", {sat_hi_o, sat_lo_o}); end
      tick();
      total++; if (f_sel_o !== 8'd127) begin bad++; $display("FAIL init_idle_f_sel got=%0d exp=127", f_sel_o); end
   endtask

   task automatic test_basic_slew();
      int exp_f[3] = '{131, 135, 137};
      do_reset();
      send_code(10, 1'b0);
      total++; if (target_o !== 8'd137) begin bad++; $display("FAIL basic_target got=%0d exp=137", target_o); end
      total++; if (f_sel_o !== 8'd127) begin bad++; $display("FAIL basic_edge0_f_sel got=%0d exp=127", f_sel_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (f_sel_o !== exp_f[i][7:0]) begin bad++; $display("FAIL basic_step%0d got=%0d exp=%0d", i + 1, f_sel_o, exp_f[i]); end
         total++; if (settled_o !== (i == 2)) begin bad++; $display("FAIL basic_settled%0d got=%0b exp=%0b", i + 1, settled_o, (i == 2)); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_code(10, 1'b0);
      tick();
      tick();
      total++; if (f_sel_o !== 8'd135) begin bad++; $display("FAIL areset_pre got=%0d exp=135", f_sel_o); end
      #2 rst_n_i = 1'b0;
      #1;
      total++; if (f_sel_o !== 8'd127) begin bad++; $display("FAIL areset_f_sel got=%0d exp=127", f_sel_o); end
      total++; if (target_o !== 8'd127) begin bad++; $display("FAIL areset_target got=%0d exp=127", target_o); end
      tick();
      rst_n_i = 1'b1;
   endtask

   task automatic test_saturation();
      int exp_f;
      do_reset();
      send_code(200, 1'b0);
      total++; if (target_o !== 8'd255) begin bad++; $display("FAIL sat_hi_target got=%0d exp=255", target_o); end
      total++; if ({sat_hi_o, sat_lo_o} !== 2'b10) begin bad++; $display("FAIL sat_hi_flags got=%b exp=10", {sat_hi_o, sat_lo_o}); end
      tick();
      total++; if (f_sel_o !== 8'd131) begin bad++; $display("FAIL sat_up_step got=%0d exp=131", f_sel_o); end
      send_code(-200, 1'b0);
      total++; if (target_o !== 8'd0) begin bad++; $display("FAIL sat_lo_target got=%0d exp=0", target_o); end
      total++; if ({sat_hi_o, sat_lo_o} !== 2'b01) begin bad++; $display("FAIL sat_lo_flags got=%b exp=01", {sat_hi_o, sat_lo_o}); end
      total++; if (f_sel_o !== 8'd135) begin bad++; $display("FAIL sat_old_target_step got=%0d exp=135", f_sel_o); end
      exp_f = 135;
      while (exp_f != 0) begin
         tick();
         exp_f = (exp_f > 4) ? exp_f - 4 : 0;
         total++; if (f_sel_o !== exp_f[7:0]) begin bad++; $display("FAIL sat_ramp_down got=%0d exp=%0d", f_sel_o, exp_f); end
      end
      total++; if (settled_o !== 1'b1) begin bad++; $display("FAIL sat_settled_at_zero got=%0b exp=1", settled_o); end
      tick();
      total++; if (f_sel_o !== 8'd0) begin bad++; $display("FAIL sat_no_wrap got=%0d exp=0", f_sel_o); end
   endtask

   task automatic test_invert();
      do_reset();
      send_code(10, 1'b0);
      total++; if (target_inv !== 8'd117) begin bad++; $display("FAIL inv_target got=%0d exp=117", target_inv); end
      total++; if ({sat_hi_inv, sat_lo_inv} !== 2'b00) begin bad++; $display("FAIL inv_flags got=%b exp=00", {sat_hi_inv, sat_lo_inv}); end
      tick();
      total++; if (f_sel_inv !== 8'd123) begin bad++; $display("FAIL inv_step got=%0d exp=123", f_sel_inv); end
      send_code(200, 1'b0);
      total++; if (target_inv !== 8'd0) begin bad++; $display("FAIL inv_sat_target got=%0d exp=0", target_inv); end
      total++; if (sat_lo_inv !== 1'b1) begin bad++; $display("FAIL inv_sat_lo got=%0b exp=1", sat_lo_inv); end
   endtask

   task automatic test_no_step_limit();
      do_reset();
      send_code(-50, 1'b0);
      total++; if (target_ns !== 8'd77) begin bad++; $display("FAIL nolimit_target got=%0d exp=77", target_ns); end
      total++; if (f_sel_ns !== 8'd127) begin bad++; $display("FAIL nolimit_edge0 got=%0d exp=127", f_sel_ns); end
      tick();
      total++; if (f_sel_ns !== 8'd77) begin bad++; $display("FAIL nolimit_jump got=%0d exp=77", f_sel_ns); end
      total++; if (settled_ns !== 1'b1) begin bad++; $display("FAIL nolimit_settled got=%0b exp=1", settled_ns); end
   endtask

   task automatic test_freeze();
      int exp_f[3] = '{139, 143, 147};
      do_reset();
      send_code(20, 1'b0);
      tick();
      tick();
      total++; if (f_sel_o !== 8'd135) begin bad++; $display("FAIL frz_pre got=%0d exp=135", f_sel_o); end
      freeze_i = 1'b1;
      tick();
      total++; if (f_sel_o !== 8'd135) begin bad++; $display("FAIL frz_hold got=%0d exp=135", f_sel_o); end
      send_code(-20, 1'b1);
      total++; if (target_o !== 8'd147) begin bad++; $display("FAIL frz_code_dropped got=%0d exp=147", target_o); end
      total++; if (f_sel_o !== 8'd135) begin bad++; $display("FAIL frz_hold2 got=%0d exp=135", f_sel_o); end
      total++; if (settled_o !== 1'b0) begin bad++; $display("FAIL frz_settled got=%0b exp=0", settled_o); end
      freeze_i = 1'b0;
      tick();
      total++; if (f_sel_o !== 8'd135) begin bad++; $display("FAIL frz_release_edge got=%0d exp=135", f_sel_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (f_sel_o !== exp_f[i][7:0]) begin bad++; $display("FAIL frz_resume%0d got=%0d exp=%0d", i, f_sel_o, exp_f[i]); end
      end
      total++; if (settled_o !== 1'b1) begin bad++; $display("FAIL frz_resettled got=%0b exp=1", settled_o); end
      // Code and freeze on the same edge: freeze wins.
      send_code(-20, 1'b1);
      total++; if (target_o !== 8'd147) begin bad++; $display("FAIL frz_simul_target got=%0d exp=147", target_o); end
      total++; if (settled_o !== 1'b0) begin bad++; $display("FAIL frz_simul_settled got=%0b exp=0", settled_o); end
      freeze_i = 1'b0;
      tick();
      total++; if (settled_o !== 1'b1) begin bad++; $display("FAIL frz_equal_release got=%0b exp=1", settled_o); end
      // Freeze in INIT: codes are ignored and the mapper stays at BIAS.
      do_reset();
      send_code(10, 1'b1);
      freeze_i = 1'b0;
      tick();
      total++; if (target_o !== 8'd127) begin bad++; $display("FAIL frz_init_target got=%0d exp=127", target_o); end
      total++; if (f_sel_o !== 8'd127) begin bad++; $display("FAIL frz_init_f_sel got=%0d exp=127", f_sel_o); end
   endtask

   task automatic test_retarget();
      int exp_f[4] = '{131, 127, 123, 119};
      do_reset();
      send_code(40, 1'b0);
      total++; if (target_o !== 8'd167) begin bad++; $display("FAIL rt_target1 got=%0d exp=167", target_o); end
      tick();
      send_code(-8, 1'b0);
      total++; if (target_o !== 8'd119) begin bad++; $display("FAIL rt_target2 got=%0d exp=119", target_o); end
      total++; if (f_sel_o !== 8'd135) begin bad++; $display("FAIL rt_edge got=%0d exp=135", f_sel_o); end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (f_sel_o !== exp_f[i][7:0]) begin bad++; $display("FAIL rt_step%0d got=%0d exp=%0d", i, f_sel_o, exp_f[i]); end
      end
      total++; if (settled_o !== 1'b1) begin bad++; $display("FAIL rt_settled got=%0b exp=1", settled_o); end
   endtask

   initial begin
      rst_n_i    = 1'b0;
      cc_valid_i = 1'b0;
      freeze_i   = 1'b0;
      dco_cc_i   = '0;
      #1;
      test_reset();
      test_basic_slew();
      test_async_reset();
      test_saturation();
      test_invert();
      test_no_step_limit();
      test_freeze();
      test_retarget();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dco_code_mapper.md
Name: dco_code_mapper

Overview:
- Converts the signed DCO control code from the loop filter into the unsigned ring-oscillator frequency-select word: f_sel = BIAS ± code.
- Saturates at the RO range instead of wrapping.
- Slew-limits changes to f_sel so large code jumps do not glitch the oscillator.
- Sits between the loop filter and the ring-oscillator tap-select logic; adds freeze, settle and saturation status.

Parameters:
- RO_WIDTH, 8, width of the f_sel_o word; valid range 0..2^RO_WIDTH-1.
- DCO_CC_WIDTH, 9, width of the signed control code (two's complement).
- BIAS, 127, centre f_sel value at code 0. Must satisfy 0 <= BIAS <= 2^RO_WIDTH-1.
- INVERT, 0, when 1 the mapping is f_sel = BIAS - code (polarity swap for negative-slope oscillators).
- MAX_STEP, 4, maximum change of f_sel_o per clock. 0 = no limit (output jumps straight to target).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- dco_cc_i  in  DCO_CC_WIDTH  signed control code.
- cc_valid_i  in  1  one-cycle strobe; dco_cc_i is sampled when high.
- freeze_i  in  1  holds f_sel_o and the target while high.
- f_sel_o  out  RO_WIDTH  registered frequency-select word.
- target_o  out  RO_WIDTH  registered clamped target.
- sat_hi_o  out  1  last sampled code clamped at the top.
- sat_lo_o  out  1  last sampled code clamped at 0.
- settled_o  out  1  f_sel_o == target_o, not frozen, and at least one code received since reset.

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - f_sel_o = target_o = BIAS.
  - sat_hi_o = sat_lo_o = settled_o = 0.
  - State = INIT.
  - Applies immediately, including mid-slew.
- Target stage (cc_valid_i=1 and freeze_i=0):
  - Sign-extend dco_cc_i and zero-extend BIAS to a common signed width of max(RO_WIDTH, DCO_CC_WIDTH)+2 bits.
  - Form sum = BIAS + code, or BIAS - code when INVERT=1.
  - sum < 0: target_o <= 0, sat_lo_o <= 1.
  - sum > 2^RO_WIDTH-1: target_o <= 2^RO_WIDTH-1, sat_hi_o <= 1.
  - Otherwise: target_o <= sum, both sat flags <= 0.
  - Latency: target_o updates on the clock edge that samples cc_valid_i.
- Slew stage, every cycle while state == SLEW:
  - diff = target_o - f_sel_o (signed).
  - MAX_STEP == 0 or |diff| <= MAX_STEP: f_sel_o <= target_o.
  - Otherwise: f_sel_o <= f_sel_o ± MAX_STEP, toward the target.
  - f_sel_o never overshoots the target and never leaves 0..2^RO_WIDTH-1.
  - Slew uses the target_o value registered at the previous edge, so f_sel_o first moves one cycle after the valid edge.
- State machine:
  - INIT: f_sel_o = BIAS. First accepted cc_valid_i -> SLEW.
  - SLEW: on the edge where f_sel_o becomes equal to target_o -> SETTLED.
  - SETTLED: a new accepted cc_valid_i with target != f_sel_o -> SLEW. Equal target stays SETTLED.
  - FROZEN: entered from any non-INIT state while freeze_i=1. All registers hold; cc_valid_i is ignored and the code is dropped, not queued. On freeze_i=0, go to SETTLED if f_sel_o == target_o, else SLEW.
  - freeze_i in INIT: stays INIT; codes are ignored.
- settled_o is a registered output, high exactly in state SETTLED.
- A new valid during SLEW retargets immediately; the slew continues from the current f_sel_o with no restart delay.
- Simultaneous cc_valid_i and freeze_i rising: freeze wins and the code is dropped.

Test Plan:
- Reset, defaults -> f_sel_o=127, target_o=127, settled_o=0. Pulse rst_n_i low mid-slew at f_sel_o=135 -> f_sel_o=127 asynchronously.
- Code +10, MAX_STEP=4 -> target_o=137 at edge 0; f_sel_o=131, 135, 137 at edges 1, 2, 3; settled_o=1 at edge 3.
- Code +200 -> target_o=255, sat_hi_o=1. Then code -200 -> target_o=0, sat_lo_o=1, sat_hi_o=0. f_sel_o ramps down in steps of 4 without overshoot or wrap.
- INVERT=1, code +10 -> target_o=117. MAX_STEP=0, code -50 (INVERT=0) -> f_sel_o=77 one cycle after target_o.
- Code +20; assert freeze_i at f_sel_o=135 and pulse cc_valid_i with code -20 while frozen -> f_sel_o holds 135, target_o stays 147. Release -> resumes 139, 143, 147; settled.
- Retarget mid-slew: code +40, then code -8 when f_sel_o=135 -> steps 131, 127, 123, 119; settled at 119.
